sysbus_arbiter: RTL
===================

// Module: sysbus_arbiter
// PURPOSE
//  N-channel Sysbus master replacing the single-requester memory fetch path: icache, dcache and
//  future clients each issue whole-block reads or writes; the block arbitrates round-robin, runs
//  one bus transaction at a time (address beat, write data beats or read response beats) and
//  returns a full block per read. Sits between the caches and the top-level bus_* ports.
// PARAMETERS
//  NCH            2    number of requesting channels (1..8); channel 0 = icache
//  WORDSZ         64   address width
//  BUS_DATA_WIDTH 64   bus beat width
//  BUS_TAG_WIDTH  13   bus tag width
//  BLOCKSZ        512  block size in bits; BEATS = BLOCKSZ/BUS_DATA_WIDTH (8)
//  TAG_TYPE       4'h1 tag[11:8] transaction type field (memory)
// PORTS
//  clk          in   1                 clock
//  reset        in   1                 asynchronous reset, active-low
//  ch_req       in   NCH               per-channel request level; held until ch_done
//  ch_wr        in   NCH               1 = block write, 0 = block read; stable while ch_req
//  ch_addr      in   NCH*WORDSZ        per-channel block address (flattened, ch0 at LSBs)
//  ch_wdata     in   NCH*BLOCKSZ       per-channel write block (flattened)
//  ch_rdata     out  BLOCKSZ           assembled read block, valid with ch_done
//  ch_done      out  NCH               one-cycle completion pulse, one-hot
//  ch_busy      out  NCH               channel currently owns the bus
//  bus_reqcyc   out  1                 request cycle
//  bus_req      out  BUS_DATA_WIDTH    address beat then write data beats
//  bus_reqtag   out  BUS_TAG_WIDTH     {wr, TAG_TYPE, 8'(channel)}
//  bus_reqack   in   1                 bus accepted address beat
//  bus_respcyc  in   1                 response beat valid
//  bus_resp     in   BUS_DATA_WIDTH    response data beat
//  bus_resptag  in   BUS_TAG_WIDTH     response tag
//  bus_respack  out  1                 response beat acknowledge
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, rr pointer=NCH-1, beat cnt=0; bus_reqcyc, bus_respack,
//    bus_req, bus_reqtag, ch_rdata, ch_done, ch_busy all 0. Reset mid-transaction aborts
//    immediately; bus_reqcyc drops in same cycle; partial read data discarded, no ch_done.
//  - IDLE: if any ch_req, grant first requester after rr pointer (cyclic); latch index, wr,
//    addr with low log2(BLOCKSZ/8) bits forced 0, wdata; rr pointer <= granted; -> ADDR next
//    cycle. Requests arriving in ADDR..DONE wait; no preemption.
//  - ADDR: bus_reqcyc=1, bus_req=aligned addr, bus_reqtag as above; hold until bus_reqack.
//    On ack: wr -> WDATA (cnt=0), else -> RESP (cnt=0).
//  - WDATA: bus_reqcyc=1, bus_req=wdata[cnt*64+:64], one beat per cycle, no per-beat ack;
//    after beat BEATS-1 -> DONE. Write: no response expected.
//  - RESP: bus_reqcyc=0; on bus_respcyc: bus_respack=1 same cycle (combinational),
//    beat stored to ch_rdata[cnt*64+:64], cnt++; gaps (respcyc=0) allowed, cnt holds.
//    bus_resptag not checked (single outstanding). After beat BEATS-1 -> DONE.
//  - DONE: ch_done[idx]=1 for exactly one cycle; ch_rdata stable from DONE until next read
//    completes its first beat; -> IDLE. A requester still holding ch_req in the next IDLE cycle
//    is a new request (still subject to round-robin).
//  - ch_busy[idx]=1 from ADDR through DONE inclusive.
//  - Min latency read: grant->ADDR 1 cyc, ack same cycle, BEATS resp cycles, DONE: BEATS+2 min.
//  - cnt width clog2(BEATS); wraps to 0 on leaving WDATA/RESP.
// TESTING
//  1 ch0 read 0x1008, ack on 1st ADDR cycle, 8 beats 0x0..0x7 back-to-back -> bus_req=0x1000,
//    tag=0x0100, ch_rdata[63:0]=0, [511:448]=7, ch_done=01 exactly 10 cycles after ch_req.
//  2 ch0 and ch1 request same cycle, both held -> grant order ch0, ch1, ch0 (round-robin),
//    never two ch_done bits set, ch_busy one-hot.
//  3 ch1 write 0x2000, wdata beat k=k+0xA0, reqack delayed 3 cycles -> reqcyc held 3 cycles
//    with addr, then beats 0xA0..0xA7 consecutive, tag=0x1101, ch_done=10.
//  4 read with respcyc gaps (beats at cycles 0,2,5,...) -> respack only on respcyc cycles,
//    assembled block identical to gap-free case.
//  5 assert reset low during RESP beat 4 -> bus_reqcyc/respack 0 immediately, no ch_done;
//    after release, new ch0 read completes correctly with fresh data.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// Round-robin Sysbus master: arbitrates N cache channels and runs one whole-block
// read or write at a time (address beat, then write beats or read response beats).
module sysbus_arbiter #(
  parameter int         NCH            = 2,
  parameter int         WORDSZ         = 64,
  parameter int         BUS_DATA_WIDTH = 64,
  parameter int         BUS_TAG_WIDTH  = 13,
  parameter int         BLOCKSZ        = 512,
  parameter logic [3:0] TAG_TYPE       = 4'h1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NCH-1:0]              ch_req,
  input  logic [NCH-1:0]              ch_wr,
  input  logic [NCH*WORDSZ-1:0]       ch_addr,
  input  logic [NCH*BLOCKSZ-1:0]      ch_wdata,
  output logic [BLOCKSZ-1:0]          ch_rdata,
  output logic [NCH-1:0]              ch_done,
  output logic [NCH-1:0]              ch_busy,
  output logic                        bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]   bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
  input  logic                        bus_reqack,
  input  logic                        bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
  output logic                        bus_respack
);
  localparam int BDW   = BUS_DATA_WIDTH;
  localparam int BEATS = BLOCKSZ / BUS_DATA_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int OFFW  = $clog2(BLOCKSZ / 8);
  localparam logic [CW-1:0]     LAST       = CW'(BEATS - 1);
  localparam logic [WORDSZ-1:0] ALIGN_MASK = {WORDSZ{1'b1}} << OFFW;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RESP, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d, idx_q, idx_d;
  logic                 wr_q, wr_d;
  logic [WORDSZ-1:0]    addr_q, addr_d;
  logic [BLOCKSZ-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 reqcyc_q, reqcyc_d;
  logic [BDW-1:0]       req_q, req_d;
  logic [BUS_TAG_WIDTH-1:0] reqtag_q, reqtag_d;
  logic [NCH-1:0]       done_q, done_d, busy_q, busy_d;

  logic                 gnt_valid;
  logic [IW-1:0]        gnt_idx;
  int                   cand;

  // Only one transaction is ever outstanding, so the response tag carries no information.
  logic unused_resptag;
  assign unused_resptag = ^bus_resptag;

  // Cyclic search starting just after the last granted channel.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NCH; i++) begin
      cand = (int'(rr_q) + i) % NCH;
      if (!gnt_valid && ch_req[cand[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    reqcyc_d = reqcyc_q;
    req_d    = req_q;
    reqtag_d = reqtag_q;
    done_d   = '0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d  = ADDR;
          rr_d     = gnt_idx;
          idx_d    = gnt_idx;
          wr_d     = ch_wr[gnt_idx];
          addr_d   = ch_addr[gnt_idx*WORDSZ +: WORDSZ] & ALIGN_MASK;
          wdata_d  = ch_wdata[gnt_idx*BLOCKSZ +: BLOCKSZ];
          reqcyc_d = 1'b1;
          req_d    = BDW'(addr_d);
          reqtag_d = BUS_TAG_WIDTH'({ch_wr[gnt_idx], TAG_TYPE, 8'(gnt_idx)});
          busy_d   = '0;
          busy_d[gnt_idx] = 1'b1;
        end
      end
      ADDR: begin
        if (bus_reqack) begin
          cnt_d = '0;
          if (wr_q) begin
            state_d = WDATA;
            req_d   = wdata_q[0 +: BDW];
          end else begin
            state_d  = RESP;
            reqcyc_d = 1'b0;
            req_d    = '0;
          end
        end
      end
      WDATA: begin
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          reqcyc_d = 1'b0;
          req_d    = '0;
          done_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          req_d = wdata_q[(int'(cnt_q) + 1)*BDW +: BDW];
        end
      end
      RESP: begin
        if (bus_respcyc) begin
          rdata_d[int'(cnt_q)*BDW +: BDW] = bus_resp;
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            done_d[idx_q] = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        busy_d   = '0;
        reqtag_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_q     <= IW'(NCH - 1);
      idx_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      reqcyc_q <= 1'b0;
      req_q    <= '0;
      reqtag_q <= '0;
      done_q   <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      reqcyc_q <= reqcyc_d;
      req_q    <= req_d;
      reqtag_q <= reqtag_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Response handshake is combinational so a beat is accepted in the cycle it is offered.
  assign bus_respack = (state_q == RESP) && bus_respcyc;
  assign bus_reqcyc  = reqcyc_q;
  assign bus_req     = req_q;
  assign bus_reqtag  = reqtag_q;
  assign ch_rdata    = rdata_q;
  assign ch_done     = done_q;
  assign ch_busy     = busy_q;
endmodule
